mtm_alu_serializer: RTL and testbench

Transmit side of the ALU serial link. It accepts a result word C with its flags, or an error code, from the ALU core through a valid/ready handshake, and frames it onto the single-bit line sout. The frame format uses the same 11-bit packet format the input deserializer decodes: start 0, type bit, 8 data bits MSB first, stop 1. The block sits between the ALU core and the top-level sout pin.

---
 rtl/mtm_alu_pkg.sv | 32 +++
 rtl/mtm_alu_serializer_if.sv | 12 +
 rtl/mtm_alu_crc3.sv | 20 ++
 rtl/mtm_alu_serializer.sv | 180 ++++++++++++++++++
 tb/tb_mtm_alu_serializer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared constants and state encoding for the ALU serial transmit path.
// The GAP state is only present when MTM_ALU_SER_GAP_EN is defined.
package mtm_alu_pkg;

    localparam logic START     = 1'b0;
    localparam logic STOP      = 1'b1;
    localparam logic TYPE_DATA = 1'b0;
    localparam logic TYPE_CTL  = 1'b1;

    localparam logic [2:0] ERR_DATA = 3'b100;
    localparam logic [2:0] ERR_CRC  = 3'b010;
    localparam logic [2:0] ERR_OP   = 3'b001;

    // Packet index of the ctl packet, i.e. the last packet of a data frame.
    localparam logic [2:0] LAST_DATA_PKT = 3'd4;

`ifdef MTM_ALU_SER_GAP_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Result handshake between the ALU core (master) and the serializer (slave).
interface mtm_alu_serializer_if;
    logic        res_valid;
    logic        res_ready;
    logic        res_err;
    logic [31:0] C;
    logic [3:0]  FLAGS;
    logic [2:0]  ERR;

    modport master (output res_valid, res_err, C, FLAGS, ERR, input res_ready);
    modport slave  (input res_valid, res_err, C, FLAGS, ERR, output res_ready);
endinterface

// File: rtl/mtm_alu_crc3.sv
// Combinational CRC3 (x^3+x+1, init 000) over a 37-bit word, MSB first.
module mtm_alu_crc3 (
    input  logic [36:0] data_i,
    output logic [2:0]  crc_o
);

    function automatic logic [2:0] crc3_calc(input logic [36:0] d);
        logic [2:0] crc;
        logic       fb;
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            fb  = crc[2] ^ d[i];
            crc = {crc[1], crc[0] ^ fb, fb};
        end
        return crc;
    endfunction

    assign crc_o = crc3_calc(data_i);

endmodule

// File: rtl/mtm_alu_serializer.sv
// Frames ALU results / error codes into 11-bit packets on sout.
// Optional inter-packet idle gap enabled by defining MTM_ALU_SER_GAP_EN.
module mtm_alu_serializer
    import mtm_alu_pkg::*;
#(
    parameter int GAP_BITS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    mtm_alu_serializer_if.slave        bus,
    output logic                       sout,
    output logic                       busy
);

    localparam bit GAP_NZ = (GAP_BITS > 0);

    state_t      state_q, state_d;
    logic        sout_q, sout_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  pkt_cnt_q, pkt_cnt_d;
    logic [9:0]  shift_q, shift_d;
    logic [31:0] c_q, c_d;
    logic [3:0]  flags_q, flags_d;
    logic [2:0]  err_q, err_d;
    logic        res_err_q, res_err_d;

    logic [9:0]  tail;
    logic [2:0]  crc;
    logic        err_par;
    logic        last_pkt;

`ifdef MTM_ALU_SER_GAP_EN
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
`else
    logic unused_gap_cfg;
    assign unused_gap_cfg = GAP_NZ;
`endif

    mtm_alu_crc3 u_crc (
        .data_i ({c_q, 1'b0, flags_q}),
        .crc_o  (crc)
    );

    assign err_par  = ^{1'b1, err_q, err_q};
    assign last_pkt = res_err_q ? (pkt_cnt_q == 3'd0) : (pkt_cnt_q == LAST_DATA_PKT);

    // Bits 1..10 of the current packet; the start bit is driven directly in LOAD.
    always_comb begin
        tail = {TYPE_DATA, c_q[31:24], STOP};
        if (res_err_q) begin
            tail = {TYPE_CTL, 1'b1, err_q, err_q, err_par, STOP};
        end else begin
            case (pkt_cnt_q)
                3'd0:    tail = {TYPE_DATA, c_q[31:24], STOP};
                3'd1:    tail = {TYPE_DATA, c_q[23:16], STOP};
                3'd2:    tail = {TYPE_DATA, c_q[15:8], STOP};
                3'd3:    tail = {TYPE_DATA, c_q[7:0], STOP};
                default: tail = {TYPE_CTL, 1'b0, flags_q, crc, STOP};
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        sout_d    = sout_q;
        bit_cnt_d = bit_cnt_q;
        pkt_cnt_d = pkt_cnt_q;
        shift_d   = shift_q;
        c_d       = c_q;
        flags_d   = flags_q;
        err_d     = err_q;
        res_err_d = res_err_q;
`ifdef MTM_ALU_SER_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                sout_d = STOP;
                if (bus.res_valid) begin
                    c_d       = bus.C;
                    flags_d   = bus.FLAGS;
                    err_d     = bus.ERR;
                    res_err_d = bus.res_err;
                    pkt_cnt_d = 3'd0;
                    bit_cnt_d = 4'd0;
                    sout_d    = START;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                sout_d    = tail[9];
                shift_d   = {tail[8:0], 1'b1};
                bit_cnt_d = 4'd1;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_d = 4'd0;
`ifdef MTM_ALU_SER_GAP_EN
                    if (GAP_NZ) begin
                        sout_d    = STOP;
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                    end else
`endif
                    if (last_pkt) begin
                        sout_d    = STOP;
                        pkt_cnt_d = 3'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        sout_d    = START;
                        pkt_cnt_d = pkt_cnt_q + 3'd1;
                        state_d   = ST_LOAD;
                    end
                end else begin
                    sout_d    = shift_q[9];
                    shift_d   = {shift_q[8:0], 1'b1};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
`ifdef MTM_ALU_SER_GAP_EN
            ST_GAP: begin
                sout_d = STOP;
                if (gap_cnt_q == GW'(GAP_BITS - 1)) begin
                    if (last_pkt) begin
                        pkt_cnt_d = 3'd0;
                        state_d   = ST_IDLE;
                    end else begin
                        sout_d    = START;
                        pkt_cnt_d = pkt_cnt_q + 3'd1;
                        state_d   = ST_LOAD;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
`endif
            default: begin
                sout_d  = STOP;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sout_q    <= STOP;
            bit_cnt_q <= '0;
            pkt_cnt_q <= '0;
            shift_q   <= '0;
            c_q       <= '0;
            flags_q   <= '0;
            err_q     <= '0;
            res_err_q <= 1'b0;
`ifdef MTM_ALU_SER_GAP_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sout_q    <= sout_d;
            bit_cnt_q <= bit_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            shift_q   <= shift_d;
            c_q       <= c_d;
            flags_q   <= flags_d;
            err_q     <= err_d;
            res_err_q <= res_err_d;
`ifdef MTM_ALU_SER_GAP_EN
            gap_cnt_q <= gap_cnt_d;
`endif
        end
    end

    assign sout          = sout_q;
    assign busy          = (state_q != ST_IDLE);
    assign bus.res_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed self-checking bench for mtm_alu_serializer (data, error, handshake, reset).
module tb_mtm_alu_serializer;

    localparam int GAP = 2;
`ifdef MTM_ALU_SER_GAP_EN
    localparam int PKT_GAP = GAP;
`else
    localparam int PKT_GAP = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sout;
    logic busy;

    mtm_alu_serializer_if bus ();

    mtm_alu_serializer #(.GAP_BITS(GAP)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .sout (sout),
        .busy (busy)
    );

    logic [36:0] crc_in;
    logic [2:0]  crc_out;
    mtm_alu_crc3 u_model (
        .data_i (crc_in),
        .crc_o  (crc_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [79:0] exp_v;
    int          exp_n;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_exp();
        exp_v = '0;
        exp_n = 0;
    endtask

    task automatic add_pkt(input logic typ, input logic [7:0] payload);
        exp_v = (exp_v << 11) | 80'({1'b0, typ, payload, 1'b1});
        exp_n += 11;
        for (int g = 0; g < PKT_GAP; g++) begin
            exp_v = {exp_v[78:0], 1'b1};
            exp_n++;
        end
    endtask

    // Accept on the next posedge, then sample one bit per cycle at negedge.
    task automatic run_frame(input string tag, input logic keep_valid, input logic [31:0] next_c);
        logic [79:0] obs;
        logic        busy_all;
        logic        ready_any;
        obs       = '0;
        busy_all  = 1'b1;
        ready_any = 1'b0;
        @(posedge clk);
        #1;
        if (keep_valid) bus.C = next_c;
        else            bus.res_valid = 1'b0;
        for (int i = 0; i < exp_n; i++) begin
            @(negedge clk);
            obs       = {obs[78:0], sout};
            busy_all  = busy_all & busy;
            ready_any = ready_any | bus.res_ready;
        end
        chk({tag, "_bits"}, obs, exp_v);
        chk({tag, "_busy"}, 80'(busy_all), 80'd1);
        chk({tag, "_ready_low"}, 80'(ready_any), 80'd0);
        @(negedge clk);
        chk({tag, "_idle"}, 80'({bus.res_ready, busy, sout}), 80'(3'b101));
        $display("txn %s bits=%0d", tag, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic stay_high;
        bus.res_valid = 1'b0;
        bus.res_err   = 1'b0;
        bus.C         = '0;
        bus.FLAGS     = '0;
        bus.ERR       = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_held", 80'({bus.res_ready, busy, sout}), 80'(3'b101));
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release", 80'({bus.res_ready, busy, sout}), 80'(3'b101));
        $display("txn reset");

        // CRC model against a hand-derived value
        crc_in = {32'h1234_5678, 1'b0, 4'b0001};
        #1;
        chk("crc_model", 80'(crc_out), 80'(3'b101));
        @(negedge clk);

        // Zero data frame
        bus.res_valid = 1'b1; bus.res_err = 1'b0; bus.C = 32'h0; bus.FLAGS = 4'h0;
        clear_exp();
        for (int p = 0; p < 4; p++) add_pkt(1'b0, 8'h00);
        add_pkt(1'b1, 8'b0_0000_000);
        run_frame("zero", 1'b0, 32'h0);

        // Nonzero data frame, CRC 101
        bus.res_valid = 1'b1; bus.res_err = 1'b0; bus.C = 32'h1234_5678; bus.FLAGS = 4'b0001;
        clear_exp();
        add_pkt(1'b0, 8'h12); add_pkt(1'b0, 8'h34); add_pkt(1'b0, 8'h56); add_pkt(1'b0, 8'h78);
        add_pkt(1'b1, 8'b0_0001_101);
        run_frame("data", 1'b0, 32'h0);

        // Error frames
        bus.res_valid = 1'b1; bus.res_err = 1'b1; bus.ERR = 3'b100; bus.C = 32'hFFFF_FFFF;
        clear_exp();
        add_pkt(1'b1, 8'b11001001);
        run_frame("err_data", 1'b0, 32'h0);

        bus.res_valid = 1'b1; bus.res_err = 1'b1; bus.ERR = 3'b010;
        clear_exp();
        add_pkt(1'b1, 8'b10100101);
        run_frame("err_crc", 1'b0, 32'h0);

        bus.res_valid = 1'b1; bus.res_err = 1'b1; bus.ERR = 3'b001;
        clear_exp();
        add_pkt(1'b1, 8'b10010011);
        run_frame("err_op", 1'b0, 32'h0);

        // Handshake: valid held, C changes mid-frame; second word accepted after one idle cycle
        bus.res_valid = 1'b1; bus.res_err = 1'b0; bus.ERR = 3'b000;
        bus.C = 32'h1234_5678; bus.FLAGS = 4'b0001;
        clear_exp();
        add_pkt(1'b0, 8'h12); add_pkt(1'b0, 8'h34); add_pkt(1'b0, 8'h56); add_pkt(1'b0, 8'h78);
        add_pkt(1'b1, 8'b0_0001_101);
        run_frame("hs_first", 1'b1, 32'h0000_0000);
        clear_exp();
        for (int p = 0; p < 4; p++) add_pkt(1'b0, 8'h00);
        add_pkt(1'b1, 8'b0_0001_011);
        run_frame("hs_second", 1'b0, 32'h0);

        // Reset mid-frame: sout returns high without a clock edge
        bus.res_valid = 1'b1; bus.res_err = 1'b0; bus.C = 32'h0; bus.FLAGS = 4'h0;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_frame", 80'({busy, sout}), 80'(2'b10));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", 80'({busy, sout}), 80'(2'b01));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset", 80'({bus.res_ready, busy, sout}), 80'(3'b101));
        stay_high = 1'b1;
        repeat (5) begin
            @(negedge clk);
            stay_high = stay_high & sout & ~busy;
        end
        chk("post_reset_quiet", 80'(stay_high), 80'd1);
        $display("txn reset_mid_frame");

        // Recovery frame after the abandoned one
        bus.res_valid = 1'b1; bus.res_err = 1'b1; bus.ERR = 3'b100;
        clear_exp();
        add_pkt(1'b1, 8'b11001001);
        run_frame("recover", 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
